// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared fetch state, instruction field positions and reset PC
package processor_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Field slicing shared with the decoder so both agree on the encoding.
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 29;
  localparam int V_BIT    = 28;
  localparam int FUNCT_HI = 27;
  localparam int FUNCT_LO = 25;
  localparam int RD_HI    = 24;
  localparam int RD_LO    = 21;

  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - program counter with load-target / increment / hold selection
module pc_register #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  input  logic              inc,
  input  logic [ADDR_W-1:0] inc_base,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] pc;

  // A redirect beats the sequential step; the step is taken from the consumed instruction's PC.
  always_comb begin
    pc_next = pc;
    if (load) begin
      pc_next = target;
    end else if (inc) begin
      pc_next = inc_base + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and request/ack instruction fetch with redirect squash
module instr_fetch_unit
  import processor_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DFLT),
  parameter int                PC_STEP  = 4,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  pc_target,
  input  logic               dec_ready,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         opcode,
  output logic               v,
  output logic [2:0]         funct,
  output logic [3:0]         rd,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_e       state, state_next;
  logic               squash, squash_next;
  logic [ADDR_W-1:0]  addr_q, addr_next;
  logic [ADDR_W-1:0]  pc_next;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic [CNT_W-1:0]   fetch_count_q;
  logic               ack;
  logic               hs;
  logic               latch;

  assign ack   = (state == FETCH) && imem_ack;
  assign hs    = (state == HOLD) && dec_ready;
  assign latch = ack && !squash && !pc_src;

  pc_register #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_src),
    .target  (pc_target),
    .inc     (hs),
    .inc_base(instr_pc_q),
    .pc_next (pc_next)
  );

  always_comb begin
    state_next  = state;
    squash_next = squash;
    addr_next   = addr_q;
    case (state)
      START: begin
        state_next = FETCH;
        addr_next  = pc_next;
      end
      FETCH: begin
        if (ack) begin
          squash_next = 1'b0;
          // A stale or same-cycle-redirected word is dropped and the request reissued.
          if (squash || pc_src) begin
            addr_next = pc_next;
          end else begin
            state_next = HOLD;
          end
        end else if (pc_src) begin
          squash_next = 1'b1;
        end
      end
      HOLD: begin
        if (hs || pc_src) begin
          state_next = FETCH;
          addr_next  = pc_next;
        end
      end
      default: begin
        state_next = START;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= START;
      squash        <= 1'b0;
      addr_q        <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state  <= state_next;
      squash <= squash_next;
      addr_q <= addr_next;
      if (latch) begin
        instr_q    <= imem_rdata;
        instr_pc_q <= addr_q;
      end
      // The decoder consumed the word even if a redirect drops it this cycle.
      if (hs) begin
        fetch_count_q <= fetch_count_q + CNT_W'(1);
      end
    end
  end

  assign imem_req    = (state == FETCH);
  assign imem_addr   = addr_q;
  assign instr_valid = (state == HOLD);
  assign instr       = instr_q;
  assign opcode      = instr_q[OPC_HI:OPC_LO];
  assign v           = instr_q[V_BIT];
  assign funct       = instr_q[FUNCT_HI:FUNCT_LO];
  assign rd          = instr_q[RD_HI:RD_LO];
  assign instr_pc    = instr_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, pc_src, dec_ready, imem_ack;
  logic [31:0] pc_target, imem_rdata;
  logic        imem_req, instr_valid, v;
  logic [31:0] imem_addr, instr, instr_pc;
  logic [2:0]  opcode, funct;
  logic [3:0]  rd;
  logic [15:0] fetch_count;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc_src     (pc_src),
    .pc_target  (pc_target),
    .dec_ready  (dec_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .opcode     (opcode),
    .v          (v),
    .funct      (funct),
    .rd         (rd),
    .instr_pc   (instr_pc),
    .fetch_count(fetch_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_hs  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h4A20_0000;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Next instruction to be delivered: sequential after a consumed word, or the redirect target.
  task automatic drive(input logic r, input logic dr, input logic ps, input logic [31:0] tgt, input logic ak);
    exp_t cur, nxt;
    logic hs;
    rst        = r;
    dec_ready  = dr;
    pc_src     = ps;
    pc_target  = tgt;
    imem_ack   = ak;
    imem_rdata = ak ? mem_word(imem_addr) : 32'($urandom);
    if (r) begin
      exp_q.delete();
      exp_q.push_back('{32'h0, 16'h0});
    end else if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL model: expectation queue empty");
    end else begin
      hs      = instr_valid && dr;
      cur     = exp_q[0];
      nxt.cnt = cur.cnt + (hs ? 16'd1 : 16'd0);
      nxt.pc  = ps ? tgt : cur.pc + 32'd4;
      if (hs) begin
        n_hs++;
        exp_q.push_back(nxt);
      end else if (ps) begin
        exp_q.delete();
        exp_q.push_back(nxt);
      end
    end
  endtask

  task automatic step(input logic r, input logic dr, input logic ps, input logic [31:0] tgt, input logic ak);
    @(posedge clk);
    #1;
    drive(r, dr, ps, tgt, ak);
  endtask

  task automatic rand_step();
    logic r, dr, ps, ak;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    r   = ($urandom_range(0, 299) == 0);
    dr  = ($urandom_range(0, 2) != 0);
    ps  = ($urandom_range(0, 9) == 0);
    tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : (32'($urandom) & 32'hFFFF_FFFC);
    ak  = imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
    drive(r, dr, ps, tgt, ak);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_fields"}, 32'({opcode, v, funct, rd}), 32'd0);
    check({tag, "_ipc"}, instr_pc, 32'h0);
    check({tag, "_count"}, 32'(fetch_count), 32'd0);
  endtask

  // Monitor: compares every delivery against the scoreboard and checks hold/address stability.
  initial begin
    logic        p_req, p_ack, p_rst, p_hold;
    logic [31:0] p_addr, p_instr, p_ipc, w;
    exp_t        e;
    p_req = 1'b0; p_ack = 1'b0; p_rst = 1'b1; p_hold = 1'b0;
    p_addr = '0; p_instr = '0; p_ipc = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!p_rst && p_req && !p_ack && imem_req) check("addr_stable", imem_addr, p_addr);
        if (!p_rst && p_hold && instr_valid) begin
          check("hold_instr", instr, p_instr);
          check("hold_pc", instr_pc, p_ipc);
        end
        if (instr_valid && dec_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL delivery: unexpected instruction at pc %h", instr_pc);
          end else begin
            e = exp_q.pop_front();
            w = mem_word(e.pc);
            check("deliv_pc", instr_pc, e.pc);
            check("deliv_instr", instr, w);
            check("deliv_opcode", 32'(opcode), 32'(w[31:29]));
            check("deliv_v", 32'(v), 32'(w[28]));
            check("deliv_funct", 32'(funct), 32'(w[27:25]));
            check("deliv_rd", 32'(rd), 32'(w[24:21]));
            check("deliv_count", 32'(fetch_count), 32'(e.cnt));
          end
        end
      end
      p_rst   = rst;
      p_req   = imem_req;
      p_ack   = imem_ack;
      p_addr  = imem_addr;
      p_hold  = instr_valid && !dec_ready && !pc_src;
      p_instr = instr;
      p_ipc   = instr_pc;
    end
  end

  initial begin
    rst = 1'b1; dec_ready = 1'b0; pc_src = 1'b0; pc_target = '0; imem_ack = 1'b0; imem_rdata = '0;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk_reset("rst");
    step(0, 0, 0, 0, 0);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    check("d0_valid", 32'(instr_valid), 32'd1);
    check("d0_instr", instr, 32'h4A20_0000);
    check("d0_fields", 32'({opcode, v, funct, rd}), 32'({3'd2, 1'b0, 3'd5, 4'd1}));
    check("d0_ipc", instr_pc, 32'h0);
    step(0, 0, 0, 0, 0);
    check("seq_addr4", imem_addr, 32'h4);
    check("seq_count1", 32'(fetch_count), 32'd1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_ipc", instr_pc, 32'h4);
    end
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("seq_addr8", imem_addr, 32'h8);
    step(0, 0, 1, 32'h100, 0);
    step(0, 0, 0, 0, 0);
    check("squash_addr_held", imem_addr, 32'h8);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check("squash_dropped", 32'(instr_valid), 32'd0);
    check("squash_reissue", imem_addr, 32'h100);
    step(0, 0, 1, 32'h200, 1);
    step(0, 0, 0, 0, 0);
    check("ackredir_dropped", 32'(instr_valid), 32'd0);
    check("ackredir_addr", imem_addr, 32'h200);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check("ackredir_noextra", 32'(instr_valid), 32'd1);
    check("ackredir_ipc", instr_pc, 32'h200);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk_reset("rst_ack");
    step(0, 0, 0, 0, 0);
    check("rst_first_addr", imem_addr, 32'h0);
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    force dut.fetch_count_q = 16'hFFFF;
    #1;
    release dut.fetch_count_q;
    exp_q[0].cnt = 16'hFFFF;
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("wrap_addr0", imem_addr, 32'h0);
    check("wrap_count0", 32'(fetch_count), 32'd0);

    n_hs = 0;
    for (int i = 0; i < 4000; i++) rand_step();
    check("random_deliveries", 32'(n_hs > 50), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
